// File: rtl/itof_converter_pipe_if.sv
// Valid/ready bus of the pipelined integer-to-float converter.
// The master side offers operations and takes results; the slave side is the converter.
interface itof_converter_pipe_if #(
  parameter int INT_WIDTH = 32,
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23
);
  logic                           valid_in;
  logic                           ready_out;
  logic                           valid_out;
  logic                           ready_in;
  logic [4:0]                     op;
  logic [2:0]                     rm;
  logic [INT_WIDTH-1:0]           int_in;
  logic [EXP_WIDTH+MAN_WIDTH:0]   float_out;
  logic                           NX;

  modport master (
    output valid_in, op, rm, int_in, ready_in,
    input  ready_out, valid_out, float_out, NX
  );

  modport slave (
    input  valid_in, op, rm, int_in, ready_in,
    output ready_out, valid_out, float_out, NX
  );
endinterface

// File: rtl/itof_converter_pipe.sv
// Two-stage elastic integer-to-float converter (signed/unsigned, five RISC-V rounding modes).
// Optional synchronous pipeline flush port is enabled by defining ITOF_FLUSH_EN.
module itof_converter_pipe #(
  parameter int INT_WIDTH = 32,
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23
) (
  input  logic clk,
  input  logic reset,
`ifdef ITOF_FLUSH_EN
  input  logic flush,
`endif
  itof_converter_pipe_if.slave bus
);

  localparam logic [4:0] FPU_OP_CVTIF = 5'h0C;
  localparam logic [4:0] FPU_OP_CVTUF = 5'h0D;

  localparam int LZW       = $clog2(INT_WIDTH + 1);
  localparam int EXT_WIDTH = INT_WIDTH - 1 + MAN_WIDTH + 2;
  localparam int BIAS      = (1 << (EXP_WIDTH - 1)) - 1;
  localparam logic [EXP_WIDTH-1:0] EXP_TOP = EXP_WIDTH'(BIAS + INT_WIDTH - 1);

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rm_e;

  logic                 flush_req;
  logic                 op_ok;
  logic                 s2_adv;
  logic                 accept;

  logic                 in_sgn;
  logic [INT_WIDTH-1:0] in_mag;
  rm_e                  in_rm;

  logic                 s1_valid;
  logic                 s1_sgn;
  logic [INT_WIDTH-1:0] s1_mag;
  rm_e                  s1_rm;

  logic [LZW-1:0]                 lz;
  logic [INT_WIDTH-2:0]           norm_frac;
  logic [EXT_WIDTH-1:0]           ext;
  logic [MAN_WIDTH-1:0]           mant;
  logic                           rbit;
  logic                           sticky;
  logic                           inc;
  logic [MAN_WIDTH:0]             man_sum;
  logic [EXP_WIDTH-1:0]           exp_val;
  logic [EXP_WIDTH+MAN_WIDTH:0]   res_f;
  logic                           res_nx;

`ifdef ITOF_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  function automatic logic [LZW-1:0] count_lz(input logic [INT_WIDTH-1:0] v);
    logic [LZW-1:0] n;
    logic           found;
    n     = '0;
    found = 1'b0;
    for (int i = INT_WIDTH - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + LZW'(1);
      end
    end
    return n;
  endfunction

  assign op_ok         = (bus.op == FPU_OP_CVTIF) || (bus.op == FPU_OP_CVTUF);
  assign s2_adv        = !bus.valid_out || bus.ready_in;
  assign bus.ready_out = (!s1_valid || s2_adv) && op_ok && !flush_req;
  assign accept        = bus.valid_in && bus.ready_out;

  // The most negative signed operand negates to itself, which is exactly its magnitude as unsigned.
  always_comb begin
    in_sgn = bus.int_in[INT_WIDTH-1] && (bus.op == FPU_OP_CVTIF);
    in_mag = in_sgn ? -bus.int_in : bus.int_in;
    in_rm  = (bus.rm > 3'd4) ? RM_RNE : rm_e'(bus.rm);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_sgn   <= 1'b0;
      s1_mag   <= '0;
      s1_rm    <= RM_RNE;
    end else if (flush_req) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_sgn   <= in_sgn;
      s1_mag   <= in_mag;
      s1_rm    <= in_rm;
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // The leading one is implicit, so only the bits below it are normalised; zero padding on the
  // right makes narrow integers into wide mantissas fall out with no round or sticky bits.
  always_comb begin
    lz        = count_lz(s1_mag);
    norm_frac = s1_mag[INT_WIDTH-2:0] << lz;
    ext       = {norm_frac, {(MAN_WIDTH + 2){1'b0}}};
    mant      = ext[EXT_WIDTH-1 -: MAN_WIDTH];
    rbit      = ext[EXT_WIDTH-1-MAN_WIDTH];
    sticky    = |ext[EXT_WIDTH-2-MAN_WIDTH:0];

    case (s1_rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = s1_sgn && (rbit || sticky);
      RM_RUP:  inc = !s1_sgn && (rbit || sticky);
      RM_RMM:  inc = rbit;
      default: inc = rbit && (sticky || mant[0]);
    endcase

    man_sum = {1'b0, mant} + {{MAN_WIDTH{1'b0}}, inc};
    exp_val = EXP_TOP - EXP_WIDTH'(lz) + {{(EXP_WIDTH - 1){1'b0}}, man_sum[MAN_WIDTH]};

    if (s1_mag == '0) begin
      res_f  = '0;
      res_nx = 1'b0;
    end else begin
      res_f  = {s1_sgn, exp_val, man_sum[MAN_WIDTH-1:0]};
      res_nx = rbit || sticky;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.valid_out <= 1'b0;
      bus.float_out <= '0;
      bus.NX        <= 1'b0;
    end else if (flush_req) begin
      bus.valid_out <= 1'b0;
    end else if (s2_adv) begin
      bus.valid_out <= s1_valid;
      if (s1_valid) begin
        bus.float_out <= res_f;
        bus.NX        <= res_nx;
      end
    end
  end

endmodule

// File: tb/tb_itof_converter_pipe.sv
// Self-checking bench for itof_converter_pipe: single, double and 32-bit-into-double instances
// checked against an arithmetic reference model plus hand-computed literal results.
module tb_itof_converter_pipe;

  localparam logic [4:0] CVTIF = 5'h0C;
  localparam logic [4:0] CVTUF = 5'h0D;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

`ifdef ITOF_FLUSH_EN
  logic flush_s = 1'b0;
`endif

  itof_converter_pipe_if #(.INT_WIDTH(32), .EXP_WIDTH(8),  .MAN_WIDTH(23)) bs();
  itof_converter_pipe_if #(.INT_WIDTH(64), .EXP_WIDTH(11), .MAN_WIDTH(52)) bd();
  itof_converter_pipe_if #(.INT_WIDTH(32), .EXP_WIDTH(11), .MAN_WIDTH(52)) bm();

  itof_converter_pipe #(.INT_WIDTH(32), .EXP_WIDTH(8), .MAN_WIDTH(23)) u_s (
    .clk(clk), .reset(reset),
`ifdef ITOF_FLUSH_EN
    .flush(flush_s),
`endif
    .bus(bs.slave)
  );

  itof_converter_pipe #(.INT_WIDTH(64), .EXP_WIDTH(11), .MAN_WIDTH(52)) u_d (
    .clk(clk), .reset(reset),
`ifdef ITOF_FLUSH_EN
    .flush(1'b0),
`endif
    .bus(bd.slave)
  );

  itof_converter_pipe #(.INT_WIDTH(32), .EXP_WIDTH(11), .MAN_WIDTH(52)) u_m (
    .clk(clk), .reset(reset),
`ifdef ITOF_FLUSH_EN
    .flush(1'b0),
`endif
    .bus(bm.slave)
  );

  typedef struct {
    logic [63:0] f;
    logic        nx;
  } exp_t;

  typedef struct {
    int          sel;
    logic [4:0]  op;
    logic [2:0]  rm;
    logic [63:0] val;
    logic [63:0] f;
    logic        nx;
  } vec_t;

  exp_t        q_s[$];
  exp_t        q_d[$];
  exp_t        q_m[$];
  logic        hold[3];
  logic [63:0] hold_f[3];
  logic        hold_nx[3];
  int          got[3];

  // Reference: exact magnitude, quotient/remainder split and remainder-vs-half comparison.
  function automatic void itof_model(input logic [63:0] v_in, input int iw, input int ew,
                                     input int mw, input logic signed_op, input logic [2:0] rm,
                                     output logic [63:0] f, output logic nx);
    logic [63:0] mask, v, m, q, rem, half;
    logic        sgn, inc;
    logic [2:0]  r;
    int          e, s;
    mask = (iw == 64) ? '1 : ((64'd1 << iw) - 64'd1);
    v    = v_in & mask;
    sgn  = signed_op && v[iw-1];
    m    = sgn ? ((~v + 64'd1) & mask) : v;
    f    = '0;
    nx   = 1'b0;
    if (m == 64'd0) return;
    e = 0;
    for (int i = 0; i < 64; i++) if (m[i]) e = i;
    r   = (rm > 3'd4) ? 3'd0 : rm;
    rem = 64'd0;
    if (e <= mw) begin
      q = m << (mw - e);
    end else begin
      s    = e - mw;
      q    = m >> s;
      rem  = m - (q << s);
      half = 64'd1 << (s - 1);
      case (r)
        3'd0:    inc = (rem > half) || ((rem == half) && q[0]);
        3'd1:    inc = 1'b0;
        3'd2:    inc = sgn && (rem != 64'd0);
        3'd3:    inc = !sgn && (rem != 64'd0);
        default: inc = (rem >= half);
      endcase
      q = q + {63'd0, inc};
      if (q == (64'd1 << (mw + 1))) begin
        q = q >> 1;
        e = e + 1;
      end
    end
    nx = (rem != 64'd0);
    f  = (64'(sgn) << (ew + mw)) | (64'(e + (1 << (ew - 1)) - 1) << mw)
       | (q & ((64'd1 << mw) - 64'd1));
  endfunction

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic driveIn(input int sel, input logic v, input logic [4:0] op,
                         input logic [2:0] rm, input logic [63:0] val);
    case (sel)
      0: begin bs.valid_in = v; bs.op = op; bs.rm = rm; bs.int_in = val[31:0]; end
      1: begin bd.valid_in = v; bd.op = op; bd.rm = rm; bd.int_in = val; end
      default: begin bm.valid_in = v; bm.op = op; bm.rm = rm; bm.int_in = val[31:0]; end
    endcase
  endtask

  task automatic setReady(input int sel, input logic r);
    case (sel)
      0: bs.ready_in = r;
      1: bd.ready_in = r;
      default: bm.ready_in = r;
    endcase
  endtask

  function automatic logic getReadyOut(input int sel);
    case (sel)
      0: return bs.ready_out;
      1: return bd.ready_out;
      default: return bm.ready_out;
    endcase
  endfunction

  function automatic logic getValidOut(input int sel);
    case (sel)
      0: return bs.valid_out;
      1: return bd.valid_out;
      default: return bm.valid_out;
    endcase
  endfunction

  function automatic logic [63:0] getFloat(input int sel);
    case (sel)
      0: return {32'd0, bs.float_out};
      1: return bd.float_out;
      default: return bm.float_out;
    endcase
  endfunction

  function automatic logic getNx(input int sel);
    case (sel)
      0: return bs.NX;
      1: return bd.NX;
      default: return bm.NX;
    endcase
  endfunction

  function automatic int qSize(input int sel);
    case (sel)
      0: return q_s.size();
      1: return q_d.size();
      default: return q_m.size();
    endcase
  endfunction

  task automatic scoreSide(input int sel);
    logic        vi, ro, vo, ri, nx, enx, ok;
    logic [4:0]  op;
    logic [2:0]  rm;
    logic [63:0] iv, fo, ef;
    int          iw, ew, mw;
    exp_t        e;
    vo = getValidOut(sel);
    ro = getReadyOut(sel);
    fo = getFloat(sel);
    nx = getNx(sel);
    case (sel)
      0: begin vi = bs.valid_in; ri = bs.ready_in; op = bs.op; rm = bs.rm;
               iv = {32'd0, bs.int_in}; iw = 32; ew = 8; mw = 23; end
      1: begin vi = bd.valid_in; ri = bd.ready_in; op = bd.op; rm = bd.rm;
               iv = bd.int_in; iw = 64; ew = 11; mw = 52; end
      default: begin vi = bm.valid_in; ri = bm.ready_in; op = bm.op; rm = bm.rm;
               iv = {32'd0, bm.int_in}; iw = 32; ew = 11; mw = 52; end
    endcase
    if (hold[sel]) begin
      checkVal($sformatf("hold_valid_dut%0d", sel), 64'(vo), 64'd1);
      checkVal($sformatf("hold_float_dut%0d", sel), fo, hold_f[sel]);
      checkVal($sformatf("hold_nx_dut%0d", sel), 64'(nx), 64'(hold_nx[sel]));
    end
    if (vo && ri) begin
      got[sel]++;
      ok = (qSize(sel) != 0);
      if (!ok) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_result_dut%0d: got %h expected no result", sel, fo);
      end else begin
        case (sel)
          0: e = q_s.pop_front();
          1: e = q_d.pop_front();
          default: e = q_m.pop_front();
        endcase
        checkVal($sformatf("model_float_dut%0d", sel), fo, e.f);
        checkVal($sformatf("model_nx_dut%0d", sel), 64'(nx), 64'(e.nx));
      end
    end
    if (vi && ro) begin
      itof_model(iv, iw, ew, mw, op == CVTIF, rm, ef, enx);
      e.f  = ef;
      e.nx = enx;
      case (sel)
        0: q_s.push_back(e);
        1: q_d.push_back(e);
        default: q_m.push_back(e);
      endcase
    end
    hold[sel]    = vo && !ri;
    hold_f[sel]  = fo;
    hold_nx[sel] = nx;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      q_s.delete();
      q_d.delete();
      q_m.delete();
      for (int i = 0; i < 3; i++) hold[i] = 1'b0;
    end else begin
`ifdef ITOF_FLUSH_EN
      if (flush_s) begin
        q_s.delete();
        hold[0] = 1'b0;
      end else begin
        scoreSide(0);
      end
`else
      scoreSide(0);
`endif
      scoreSide(1);
      scoreSide(2);
    end
  end

  task automatic applyStimulus(input int sel, input logic [4:0] op, input logic [2:0] rm,
                               input logic [63:0] val, output int waited);
    waited = 0;
    driveIn(sel, 1'b1, op, rm, val);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (getReadyOut(sel)) break;
      waited++;
      if (waited >= 50) begin
        checks++;
        errors++;
        $display("[TB] FAIL accept_timeout_dut%0d: got no ready_out expected ready_out=1", sel);
        break;
      end
    end
    @(posedge clk);
    #1;
    driveIn(sel, 1'b0, op, rm, val);
  endtask

  task automatic checkOutput(input int sel, input logic [63:0] ef, input logic enx,
                             input int elat, input string name);
    int cnt;
    bit seen;
    cnt  = 0;
    seen = 1'b0;
    while (cnt < 20 && !seen) begin
      @(negedge clk);
      cnt++;
      seen = getValidOut(sel);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: got no valid_out expected %h", name, ef);
    end else begin
      checkVal({name, "_float"}, getFloat(sel), ef);
      checkVal({name, "_nx"}, 64'(getNx(sel)), 64'(enx));
      if (elat > 0) checkVal({name, "_latency"}, 64'(cnt), 64'(elat));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain(input int sel, input string name);
    for (int c = 0; c < 40 && qSize(sel) != 0; c++) @(posedge clk);
    #1;
    checkVal(name, 64'(qSize(sel)), 64'd0);
  endtask

  vec_t        dir_vecs[13];
  logic [63:0] stream_vals[12];

  initial begin
    int w, total_wait, g0;
    for (int s = 0; s < 3; s++) begin
      driveIn(s, 1'b0, CVTIF, 3'd0, 64'd0);
      setReady(s, 1'b1);
      got[s] = 0;
    end

    dir_vecs[0]  = '{0, CVTIF, 3'd0, 64'h1,                  64'h3F800000,         1'b0};
    dir_vecs[1]  = '{0, CVTIF, 3'd0, 64'hFFFFFFFF,           64'hBF800000,         1'b0};
    dir_vecs[2]  = '{0, CVTUF, 3'd0, 64'hFFFFFFFF,           64'h4F800000,         1'b1};
    dir_vecs[3]  = '{0, CVTUF, 3'd1, 64'hFFFFFFFF,           64'h4F7FFFFF,         1'b1};
    dir_vecs[4]  = '{0, CVTIF, 3'd0, 64'h80000000,           64'hCF000000,         1'b0};
    dir_vecs[5]  = '{0, CVTIF, 3'd2, 64'h0,                  64'h00000000,         1'b0};
    dir_vecs[6]  = '{0, CVTIF, 3'd0, 64'h01000001,           64'h4B800000,         1'b1};
    dir_vecs[7]  = '{0, CVTIF, 3'd3, 64'h01000001,           64'h4B800001,         1'b1};
    dir_vecs[8]  = '{0, CVTIF, 3'd4, 64'h01000001,           64'h4B800001,         1'b1};
    dir_vecs[9]  = '{0, CVTIF, 3'd2, 64'hFEFFFFFF,           64'hCB800001,         1'b1};
    dir_vecs[10] = '{1, CVTUF, 3'd0, 64'h8000000000000000,   64'h43E0000000000000, 1'b0};
    dir_vecs[11] = '{1, CVTIF, 3'd0, 64'h7FFFFFFFFFFFFFFF,   64'h43E0000000000000, 1'b1};
    dir_vecs[12] = '{2, CVTIF, 3'd0, 64'h7FFFFFFF,           64'h41DFFFFFFFC00000, 1'b0};

    stream_vals = '{64'h0, 64'h1, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000,
                    64'h7FFFFFFFFFFFFFFF, 64'h0000000001000003, 64'h0020000000000801,
                    64'hDEADBEEF12345678, 64'h0000000080000001, 64'h0040000000000003,
                    64'hFFFFFFFFFEFFFFFF, 64'h00000001FFFFFFFF};

    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      checkVal($sformatf("reset_valid_out_dut%0d", s), 64'(getValidOut(s)), 64'd0);
      checkVal($sformatf("reset_float_out_dut%0d", s), getFloat(s), 64'd0);
      checkVal($sformatf("reset_nx_dut%0d", s), 64'(getNx(s)), 64'd0);
    end
    @(posedge clk);
    #1 reset = 1'b0;

    foreach (dir_vecs[i]) begin
      applyStimulus(dir_vecs[i].sel, dir_vecs[i].op, dir_vecs[i].rm, dir_vecs[i].val, w);
      checkOutput(dir_vecs[i].sel, dir_vecs[i].f, dir_vecs[i].nx, 2, $sformatf("directed%0d", i));
    end

    // Unknown opcodes must never be accepted.
    driveIn(0, 1'b1, 5'h00, 3'd0, 64'd5);
    repeat (2) begin
      @(negedge clk);
      checkVal("bad_op_ready_out", 64'(getReadyOut(0)), 64'd0);
    end
    @(posedge clk);
    #1 driveIn(0, 1'b0, CVTIF, 3'd0, 64'd0);
    repeat (3) @(negedge clk);
    checkVal("bad_op_no_result", 64'(getValidOut(0)), 64'd0);
    @(posedge clk);
    #1;

    for (int s = 0; s < 3; s++) begin
      total_wait = 0;
      foreach (stream_vals[i]) begin
        applyStimulus(s, (i % 2 == 0) ? CVTIF : CVTUF, (i == 11) ? 3'd6 : 3'(i % 5),
                      stream_vals[i], w);
        total_wait += w;
      end
      checkVal($sformatf("throughput_dut%0d", s), 64'(total_wait), 64'd0);
      waitDrain(s, $sformatf("stream_drain_dut%0d", s));

      fork
        begin
          foreach (stream_vals[i])
            applyStimulus(s, (i % 3 == 0) ? CVTUF : CVTIF, 3'((i + 2) % 5), stream_vals[i], w);
        end
        begin
          for (int c = 0; c < 40; c++) begin
            setReady(s, (c % 3) != 1);
            @(posedge clk);
            #1;
          end
          setReady(s, 1'b1);
        end
      join
      waitDrain(s, $sformatf("bp_stream_drain_dut%0d", s));
    end

    // Backpressure: two ops held, third stalled, then all three drain in order.
    setReady(0, 1'b0);
    g0 = got[0];
    applyStimulus(0, CVTIF, 3'd0, 64'h1, w);
    applyStimulus(0, CVTIF, 3'd0, 64'hFFFFFFFF, w);
    driveIn(0, 1'b1, CVTUF, 3'd0, 64'hFFFFFFFF);
    repeat (5) begin
      @(negedge clk);
      checkVal("bp_ready_out", 64'(getReadyOut(0)), 64'd0);
      checkVal("bp_valid_out", 64'(getValidOut(0)), 64'd1);
      checkVal("bp_head_float", getFloat(0), 64'h3F800000);
    end
    @(posedge clk);
    #1 setReady(0, 1'b1);
    applyStimulus(0, CVTUF, 3'd0, 64'hFFFFFFFF, w);
    waitDrain(0, "bp_drain");
    repeat (3) @(posedge clk);
    #1 checkVal("bp_result_count", 64'(got[0] - g0), 64'd3);

    // Reset with two operations in flight.
    setReady(0, 1'b0);
    applyStimulus(0, CVTIF, 3'd0, 64'd3, w);
    applyStimulus(0, CVTIF, 3'd0, 64'd4, w);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkVal("rst_valid_out", 64'(getValidOut(0)), 64'd0);
    checkVal("rst_float_out", getFloat(0), 64'd0);
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    setReady(0, 1'b1);
    repeat (6) begin
      @(negedge clk);
      checkVal("post_rst_idle", 64'(getValidOut(0)), 64'd0);
    end
    @(posedge clk);
    #1;

`ifdef ITOF_FLUSH_EN
    setReady(0, 1'b0);
    applyStimulus(0, CVTIF, 3'd0, 64'd7, w);
    @(posedge clk);
    #1;
    driveIn(0, 1'b1, CVTIF, 3'd0, 64'd5);
    flush_s = 1'b1;
    @(negedge clk);
    checkVal("flush_ready_out", 64'(getReadyOut(0)), 64'd0);
    @(posedge clk);
    #1;
    flush_s = 1'b0;
    driveIn(0, 1'b0, CVTIF, 3'd0, 64'd0);
    setReady(0, 1'b1);
    repeat (4) begin
      @(negedge clk);
      checkVal("post_flush_idle", 64'(getValidOut(0)), 64'd0);
    end
    @(posedge clk);
    #1;
    applyStimulus(0, CVTIF, 3'd0, 64'd2, w);
    checkOutput(0, 64'h40000000, 1'b0, 2, "post_flush_op");
`endif

    // Post-reset conversion must still be correct.
    applyStimulus(0, CVTIF, 3'd1, 64'hFFFFFFFF, w);
    checkOutput(0, 64'hBF800000, 1'b0, 2, "post_reset_op");

    repeat (4) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++)
      checkVal($sformatf("final_queue_empty_dut%0d", s), 64'(qSize(s)), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
